// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Handles load-use, MDU occupancy, data-memory wait states and taken-branch
// squashing with a fixed priority: memory hold, then branch, then load-use/MDU.
// Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
   parameter int MDU_LAT     = 8,
   parameter int MEM_TIMEOUT = 64,
   parameter int REG_W       = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_is_mdu,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mdu_start,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_stall,
   output logic             idex_flush,
   output logic             exmem_stall,
   output logic             mdu_busy,
   output logic             mem_err,
   output logic [15:0]      stall_cycles
);

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   localparam logic [7:0] MDU_LAT_V     = 8'(MDU_LAT);
   localparam logic [7:0] MEM_TIMEOUT_V = 8'(MEM_TIMEOUT);

   mem_state_t  state_r;
   logic [7:0]  mdu_cnt_r;
   logic [7:0]  wait_cnt_r;
   logic        mem_err_r;
   logic [15:0] stall_cycles_r;

   logic        mem_hold_s;
   logic        rs_hit_s;
   logic        rt_hit_s;
   logic        load_use_s;
   logic        mdu_hazard_s;
   logic [7:0]  wait_inc_s;

   assign mem_hold_s   = mem_req & ~mem_ready;
   assign rs_hit_s     = id_uses_rs & (id_rs == ex_rd);
   assign rt_hit_s     = id_uses_rt & (id_rt == ex_rd);
   assign load_use_s   = ex_mem_read & (ex_rd != {REG_W{1'b0}}) & (rs_hit_s | rt_hit_s);
   assign mdu_busy     = (mdu_cnt_r != 8'd0);
   assign mdu_hazard_s = id_is_mdu & mdu_busy;
   assign wait_inc_s   = (wait_cnt_r == 8'hFF) ? 8'hFF : (wait_cnt_r + 8'd1);
   assign mem_err      = mem_err_r;
   assign stall_cycles = stall_cycles_r;

   // Zero-latency stall/flush decode with fixed priority; all quiet during reset.
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_stall = 1'b0;
      if (!reset) begin
         pc_stall = 1'b0;
      end else if (mem_hold_s) begin
         // Freeze everything; a taken branch is re-seen once memory releases.
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
      end else if (branch_taken) begin
         // Squash the wrong-path instructions, which also drops any hazard in ID.
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (load_use_s || mdu_hazard_s) begin
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         idex_flush = 1'b1;
      end else begin
         pc_stall = 1'b0;
      end
   end

   // Memory wait-state FSM with timeout counter and sticky error flag.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r    <= RUN;
         wait_cnt_r <= 8'd0;
         mem_err_r  <= 1'b0;
      end else begin
         case (state_r)
            RUN: begin
               if (mem_hold_s) begin
                  // This cycle is the first wait cycle.
                  state_r    <= MEM_WAIT;
                  wait_cnt_r <= 8'd1;
                  if (8'd1 >= MEM_TIMEOUT_V) begin
                     mem_err_r <= 1'b1;
                  end else begin
                     mem_err_r <= mem_err_r;
                  end
               end else begin
                  wait_cnt_r <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state_r    <= RUN;
                  wait_cnt_r <= 8'd0;
               end else begin
                  wait_cnt_r <= wait_inc_s;
                  if (wait_inc_s >= MEM_TIMEOUT_V) begin
                     mem_err_r <= 1'b1;
                  end else begin
                     mem_err_r <= mem_err_r;
                  end
               end
            end
            default: begin
               state_r    <= RUN;
               wait_cnt_r <= 8'd0;
            end
         endcase
      end
   end

   // MDU occupancy counter: loads on an unblocked start, otherwise counts down freely.
   always_ff @(posedge clock) begin
      if (!reset) begin
         mdu_cnt_r <= 8'd0;
      end else if (ex_mdu_start && !mem_hold_s) begin
         mdu_cnt_r <= MDU_LAT_V;
      end else if (mdu_cnt_r != 8'd0) begin
         mdu_cnt_r <= mdu_cnt_r - 8'd1;
      end else begin
         mdu_cnt_r <= mdu_cnt_r;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cycles_r <= 16'd0;
      end else if (pc_stall && (stall_cycles_r != 16'hFFFF)) begin
         stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: stimulus pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  id_rs, id_rt, ex_rd;
   logic        id_uses_rs, id_uses_rt, id_is_mdu, ex_mem_read, ex_mdu_start;
   logic        branch_taken, mem_req, mem_ready;
   logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall;
   logic        mdu_busy, mem_err;
   logic [15:0] stall_cycles;

   // ctl bit order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] HOLD = 6'b110101;
   localparam logic [5:0] BR   = 6'b001010;
   localparam logic [5:0] HZ   = 6'b110010;

   typedef struct {
      string       name;
      logic [5:0]  ctl;
      logic        busy;
      logic        err;
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   pipe_hazard_ctrl #(.MDU_LAT(8), .MEM_TIMEOUT(64), .REG_W(5)) dut (
      .clock(clock), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_mdu(id_is_mdu), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_mdu_start(ex_mdu_start), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
      .mdu_busy(mdu_busy), .mem_err(mem_err), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   // Monitor: one expectation per cycle, compared away from the active edge.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [5:0] ctl;
         e   = exp_q.pop_front();
         ctl = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall};
         n_cmp++;
         if (ctl !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.name, ctl, e.ctl);
         end
         n_cmp++;
         if (mdu_busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s mdu_busy: got %b expected %b", e.name, mdu_busy, e.busy);
         end
         n_cmp++;
         if (mem_err !== e.err) begin
            n_fail++;
            $display("FAIL %s mem_err: got %b expected %b", e.name, mem_err, e.err);
         end
         n_cmp++;
         if (stall_cycles !== e.sc) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", e.name, stall_cycles, e.sc);
         end
      end
   end

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mdu = 1'b0;
      ex_mem_read = 1'b0; ex_mdu_start = 1'b0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic step(input string name, input logic [5:0] ctl, input logic busy,
                       input logic err, input int sc);
      exp_t e;
      e.name = name; e.ctl = ctl; e.busy = busy; e.err = err; e.sc = 16'(sc);
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      @(posedge clock);
      #1;
      // Reset held with a memory hold present: outputs must stay quiet.
      mem_req = 1'b1;
      step("reset_quiet", NONE, 1'b0, 1'b0, 0);
      reset = 1'b1;
      idle_inputs();
      step("idle", NONE, 1'b0, 1'b0, 0);

      // Load-use on rs: one bubble cycle.
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
      step("load_use_rs", HZ, 1'b0, 1'b0, 0);
      idle_inputs();
      step("load_use_release", NONE, 1'b0, 1'b0, 1);
      // $zero destination never hazards.
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
      step("load_rd_zero", NONE, 1'b0, 1'b0, 1);
      // Matching index but operand not read.
      ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
      step("rs_unused", NONE, 1'b0, 1'b0, 1);
      // Load-use on rt.
      id_rt = 5'd9; ex_rd = 5'd9; id_uses_rt = 1'b1;
      step("load_use_rt", HZ, 1'b0, 1'b0, 1);
      idle_inputs();
      step("rt_release", NONE, 1'b0, 1'b0, 2);

      // Branch squashes a concurrent load-use.
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1; branch_taken = 1'b1;
      step("branch_over_lu", BR, 1'b0, 1'b0, 2);
      idle_inputs();
      step("after_branch", NONE, 1'b0, 1'b0, 2);

      // MDU start, then a dependent MDU op waits out the latency.
      ex_mdu_start = 1'b1;
      step("mdu_start", NONE, 1'b0, 1'b0, 2);
      idle_inputs();
      step("mdu_run", NONE, 1'b1, 1'b0, 2);
      id_is_mdu = 1'b1;
      for (int k = 0; k < 7; k++) begin
         step("mdu_hazard", HZ, 1'b1, 1'b0, 2 + k);
      end
      step("mdu_release", NONE, 1'b0, 1'b0, 9);
      idle_inputs();

      // Memory wait with a pending branch; a start during hold must not load.
      mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1; ex_mdu_start = 1'b1;
      step("mem_hold1", HOLD, 1'b0, 1'b0, 9);
      ex_mdu_start = 1'b0;
      step("mem_hold2", HOLD, 1'b0, 1'b0, 10);
      step("mem_hold3", HOLD, 1'b0, 1'b0, 11);
      mem_ready = 1'b1;
      step("mem_done_branch", BR, 1'b0, 1'b0, 12);
      idle_inputs();
      step("after_mem", NONE, 1'b0, 1'b0, 12);

      // Timeout: 64 wait cycles set mem_err at the last edge.
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 1; i <= 64; i++) begin
         step("timeout_wait", HOLD, 1'b0, 1'b0, 11 + i);
      end
      mem_req = 1'b0; mem_ready = 1'b1;
      step("timeout_set", NONE, 1'b0, 1'b1, 76);
      idle_inputs();
      ex_mdu_start = 1'b1;
      step("err_sticky", NONE, 1'b0, 1'b1, 76);
      idle_inputs();

      // Reset mid-MDU clears everything.
      reset = 1'b0; mem_req = 1'b1;
      step("reset_edge", NONE, 1'b1, 1'b1, 76);
      reset = 1'b1;
      idle_inputs();
      step("post_reset", NONE, 1'b0, 1'b0, 0);
      mem_req = 1'b1;
      step("post_reset_hold", HOLD, 1'b0, 1'b0, 0);
      idle_inputs();
      step("post_reset_free", NONE, 1'b0, 1'b0, 1);

      // Drain the scoreboard with a bounded wait.
      for (int w = 0; w < 10 && exp_q.size() > 0; w++) begin
         @(posedge clock);
      end
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the stall and flush inputs of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, multi-cycle multiply/divide (MDU) occupancy, data-memory wait states and taken-branch squashing, with a fixed priority.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag for debug.

Parameters:
- MDU_LAT, 8, cycles the MDU is busy after a start; legal range 2..255.
- MEM_TIMEOUT, 64, consecutive wait cycles before mem_err sets; range 1..255.
- REG_W, 5, register-index width.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous, active-low.
- id_rs  in  REG_W  rs index of the instruction in ID.
- id_rt  in  REG_W  rt index of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_mdu  in  1  ID instruction is any MDU op (MULT/DIV/MFHI/MFLO).
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  REG_W  destination of the EX instruction.
- ex_mdu_start  in  1  EX instruction launches an MDU operation.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM-stage access active.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID.
- idex_stall  out  1  hold ID/EX.
- idex_flush  out  1  zero ID/EX (bubble).
- exmem_stall  out  1  hold EX/MEM.
- mdu_busy  out  1  MDU counter nonzero.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cycles  out  16  saturating count of cycles with pc_stall=1.

Behaviour:
- Reset: reset=0 at a clock edge clears all state. MEM FSM goes to RUN; mdu_cnt, wait_cnt, stall_cycles and mem_err go to 0. All stall/flush outputs are forced to 0 while reset=0. Reset mid-wait or mid-MDU aborts immediately.
- Stall/flush outputs are combinational from the inputs and registered state, with zero latency, so they act on the next edge of the pipeline registers.
- MEM FSM has two states, RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req=1 and mem_ready=0.
  - MEM_WAIT -> RUN on mem_ready=1.
  - wait_cnt increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_err sets and stays set until reset. The FSM keeps waiting.
- mem_hold = mem_req & ~mem_ready, evaluated in any state.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- mdu_hazard = id_is_mdu & mdu_busy.
- Priority, highest first:
  1. mem_hold: pc_stall, ifid_stall, idex_stall and exmem_stall all 1; all flushes 0. branch_taken is ignored because ID/EX is frozen, so the branch is re-seen after release.
  2. branch_taken: ifid_flush=1 and idex_flush=1; all stalls 0. This squashes any concurrent load_use or mdu_hazard.
  3. load_use or mdu_hazard: pc_stall=1, ifid_stall=1, idex_flush=1. load_use lasts exactly one cycle because the load advances to MEM.
  4. Otherwise all outputs are 0.
- MDU counter:
  - ex_mdu_start with no mem_hold loads mdu_cnt=MDU_LAT.
  - Otherwise, if mdu_cnt != 0, it decrements every cycle, including during mem_hold, because the MDU runs independently.
  - mdu_busy = (mdu_cnt != 0).
  - ex_mdu_start while mdu_busy is impossible, since mdu_hazard stalls it in ID. If it occurs anyway, the counter reloads.
- stall_cycles increments on every cycle with pc_stall=1 and saturates at 0xFFFF.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> exactly one cycle of pc_stall=ifid_stall=idex_flush=1; stall_cycles=1.
- ex_rd=0 with a matching id_rs=0, then id_uses_rs=0 with id_rs matching -> no stall in either case.
- MDU: ex_mdu_start pulse, then id_is_mdu=1 held (MDU_LAT=8) -> stall for 7 cycles after the start cycle; mdu_busy drops after 8 cycles; the ID instruction releases on the next cycle.
- Branch with concurrent load_use -> ifid_flush=idex_flush=1, pc_stall=0 in the same cycle.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles with branch_taken=1 -> all four stalls held and no flush. When mem_ready=1, the branch flush appears that cycle.
- Timeout and reset: mem_ready=0 for 64 cycles -> mem_err=1 and sticky after mem_ready returns. Then reset=0 for one edge -> mem_err=0, stall_cycles=0, mdu_busy=0, state RUN.
